// File: rtl/serout_shifter_if.sv
// rtl/serout_shifter_if.sv - SEROUT write/tick/pin signal bundle for serout_shifter.
// Tone inputs exist only when SEROUT_TWO_TONE_EN is defined.
interface serout_shifter_if #(
  parameter int DATA_BITS = 8
);
  logic                 enp;
  logic                 bit_tick;
  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 force_break;
`ifdef SEROUT_TWO_TONE_EN
  logic                 two_tone;
  logic                 tone1;
  logic                 tone2;
`endif
  logic                 sod;
  logic                 irq_need;
  logic                 irq_done;
  logic                 busy;

  modport master (
    output enp, bit_tick, wr_en, wr_data, force_break,
`ifdef SEROUT_TWO_TONE_EN
    output two_tone, tone1, tone2,
`endif
    input  sod, irq_need, irq_done, busy
  );

  modport slave (
    input  enp, bit_tick, wr_en, wr_data, force_break,
`ifdef SEROUT_TWO_TONE_EN
    input  two_tone, tone1, tone2,
`endif
    output sod, irq_need, irq_done, busy
  );
endinterface

// File: rtl/serout_shifter.sv
// rtl/serout_shifter.sv - POKEY SEROUT holding register and start/data/stop frame shifter.
// Optional two-tone SOD modulation is enabled by defining SEROUT_TWO_TONE_EN.
module serout_shifter #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input logic           clk,
  input logic           reset,
  serout_shifter_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS + STOP_BITS + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [DATA_BITS-1:0] shifter, shifter_next;
  logic [DATA_BITS-1:0] hold;
  logic                 hold_full;
  logic                 load;
  logic                 frame_bit;
  logic                 tick;
  logic                 irq_need_q;
  logic                 irq_done_q;
  logic                 line_bit;

  assign tick = bus.enp & bus.bit_tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shifter    <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      irq_need_q <= 1'b0;
      irq_done_q <= 1'b1;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      shifter    <= shifter_next;
      if (bus.wr_en) hold <= bus.wr_data;
      // A write on the transfer edge refills the register after the old value moves out.
      hold_full  <= bus.wr_en | (hold_full & ~load);
      irq_need_q <= load;
      irq_done_q <= (state == IDLE) & ~hold_full;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    shifter_next = shifter;
    load         = 1'b0;
    frame_bit    = 1'b1;
    case (state)
      IDLE: begin
        if (tick && hold_full) begin
          load       = 1'b1;
          state_next = START;
        end
      end
      START: begin
        frame_bit = 1'b0;
        if (tick) begin
          state_next = DATA;
          cnt_next   = '0;
        end
      end
      DATA: begin
        frame_bit = shifter[0];
        if (tick) begin
          shifter_next = shifter >> 1;
          if (cnt == CW'(DATA_BITS - 1)) begin
            state_next = STOP;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (cnt == CW'(STOP_BITS - 1)) begin
            cnt_next = '0;
            if (hold_full) begin
              load       = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) shifter_next = hold;
  end

`ifdef SEROUT_TWO_TONE_EN
  assign line_bit = bus.two_tone ? (frame_bit ? bus.tone1 : bus.tone2) : frame_bit;
`else
  assign line_bit = frame_bit;
`endif

  assign bus.sod      = line_bit & ~bus.force_break;
  assign bus.irq_need = irq_need_q;
  assign bus.irq_done = irq_done_q;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_serout_shifter.sv
// tb/tb_serout_shifter.sv - scoreboard bench for serout_shifter frames, IRQs, reset and break.
module tb_serout_shifter;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   phase = 0;
  int   need_cnt = 0;
  int   bit_idx = 0;
  bit   last_tick = 0;
  logic sb[$];

  serout_shifter_if #(.DATA_BITS(8)) bus ();

  serout_shifter #(.DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // enp every other clk, bit_tick every 16 enp
  task automatic cyc(input bit w, input logic [7:0] d);
    bus.enp      = (phase % 2 == 0);
    bus.bit_tick = (phase % 32 == 0);
    last_tick    = bus.enp && bus.bit_tick;
    bus.wr_en    = w;
    bus.wr_data  = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    phase++;
    if (bus.irq_need === 1'b1) need_cnt++;
  endtask

  task automatic wait_tick();
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cyc(1'b0, 8'h00);
      found = last_tick;
    end
    chk("tick_timeout", 32'(found), 32'd1);
  endtask

  task automatic push_frame(input logic [7:0] d);
    sb.push_back(1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(d[i]);
    sb.push_back(1'b1);
  endtask

  task automatic check_bits(input int n);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = (sb.size() != 0) ? sb.pop_front() : 1'b1;
      chk("sod", 32'(bus.sod), 32'(bus.force_break ? 1'b0 : b));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("irq_need", 32'(bus.irq_need), 32'(bit_idx % 10 == 0));
      chk("irq_done_frame", 32'(bus.irq_done), 32'd0);
      bit_idx++;
      wait_tick();
    end
  endtask

  task automatic end_frame();
    chk("busy_end", 32'(bus.busy), 32'd0);
    chk("sod_idle", 32'(bus.sod), 32'd1);
    chk("irq_done_lat", 32'(bus.irq_done), 32'd0);
    cyc(1'b0, 8'h00);
    chk("irq_done_end", 32'(bus.irq_done), 32'd1);
  endtask

  task automatic start_test();
    bit_idx  = 0;
    need_cnt = 0;
    sb.delete();
  endtask

  initial begin
    int busy_seen;
    reset           = 1'b1;
    bus.enp         = 1'b0;
    bus.bit_tick    = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_data     = '0;
    bus.force_break = 1'b0;
`ifdef SEROUT_TWO_TONE_EN
    bus.two_tone    = 1'b0;
    bus.tone1       = 1'b0;
    bus.tone2       = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sod", 32'(bus.sod), 32'd1);
    chk("rst_irq_need", 32'(bus.irq_need), 32'd0);
    chk("rst_irq_done", 32'(bus.irq_done), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;

    // 0xA5 single frame
    start_test();
    repeat (5) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hA5);
    push_frame(8'hA5);
    wait_tick();
    check_bits(10);
    end_frame();
    chk("a5_need_pulses", 32'(need_cnt), 32'd1);

    // 0x00 then 0xFF written mid-frame: back-to-back frames
    start_test();
    cyc(1'b1, 8'h00);
    push_frame(8'h00);
    wait_tick();
    check_bits(3);
    cyc(1'b1, 8'hFF);
    push_frame(8'hFF);
    check_bits(17);
    end_frame();
    chk("b2b_need_pulses", 32'(need_cnt), 32'd2);

    // 0x11 overwritten by 0x22 before any tick
    start_test();
    wait_tick();
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h22);
    push_frame(8'h22);
    wait_tick();
    check_bits(10);
    end_frame();
    chk("ovw_need_pulses", 32'(need_cnt), 32'd1);

    // async reset at data bit 4 of 0x3C
    start_test();
    cyc(1'b1, 8'h3C);
    push_frame(8'h3C);
    wait_tick();
    check_bits(5);
    #2 reset = 1'b1;
    #1;
    chk("arst_sod", 32'(bus.sod), 32'd1);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_irq_done", 32'(bus.irq_done), 32'd1);
    #5 reset = 1'b0;
    sb.delete();
    busy_seen = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1'b0, 8'h00);
      if (bus.busy !== 1'b0) busy_seen++;
    end
    chk("no_frame_after_rst", 32'(busy_seen), 32'd0);

    // force_break over first half of 0x55, released mid-period
    start_test();
    bus.force_break = 1'b1;
    cyc(1'b1, 8'h55);
    push_frame(8'h55);
    wait_tick();
    check_bits(5);
    repeat (8) cyc(1'b0, 8'h00);
    bus.force_break = 1'b0;
    #1;
    chk("brk_resume", 32'(bus.sod), 32'(sb[0]));
    check_bits(5);
    end_frame();

    // write on the exact tick cycle while idle
    start_test();
    while (phase % 32 != 0) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'hC3);
    chk("tickwr_busy", 32'(bus.busy), 32'd0);
    chk("tickwr_need", 32'(bus.irq_need), 32'd0);
    push_frame(8'hC3);
    wait_tick();
    check_bits(10);
    end_frame();
    chk("tickwr_need_pulses", 32'(need_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
